mips_cpu_bus_core: RTL and testbench
====================================

// Module: mips_cpu_bus_core
// PURPOSE
//  Multi-cycle MIPS-I subset CPU with one Avalon-style memory master port for both instruction and data.
//  Sits between the system bench and a word-wide RAM (e.g. RAM_8x4096).
//  Runs from RESET_VECTOR until it jumps to address 0, then halts with active=0 and exposes $2 on register_v0.
// PARAMETERS
//  RESET_VECTOR  32'hBFC00000  first instruction fetch address after reset
// PORTS
//  clk          in   1   single clock; all state updates on posedge
//  reset        in   1   synchronous, active-high reset
//  active       out  1   1 while executing; 0 in reset and after halt
//  register_v0  out  32  live value of GPR $2
//  address      out  32  byte address, always word-aligned (bits[1:0]=0)
//  write        out  1   write strobe
//  read         out  1   read strobe
//  waitrequest  in   1   1 = slave stalls current read/write
//  writedata    out  32  store data; lane i = writedata[8i+7:8i]
//  byteenable   out  4   byte-lane enables; 4'b1111 for fetch/LW/SW
//  readdata     in   32  read data, valid the cycle after an accepted read
// BEHAVIOUR
//  Reset, sampled on posedge: PC=RESET_VECTOR, GPRs $0..$31=0, state=FETCH, active=0, read=0, write=0, register_v0=0.
//  First cycle after reset release: active=1, read=1, address=RESET_VECTOR.
//  Reset asserted mid-instruction aborts it: no GPR write, no pending bus access completes.
//  States: FETCH -> EXEC -> (MEM if LW/SW) -> WB -> FETCH; HALT is terminal.
//  FETCH: read=1, address=PC, byteenable=4'b1111. Hold all bus outputs while waitrequest=1.
//    The access is accepted on the first posedge with waitrequest=0; readdata is latched into IR on the next cycle.
//  read and write are never asserted together; both are 0 in EXEC/WB/HALT.
//  Instructions: ADDU SUBU AND OR XOR NOR SLT SLTU SLL SRL SRA SLLV SRLV SRAV JR JALR,
//    ADDIU ANDI ORI XORI SLTI SLTIU LUI LW SW BEQ BNE BLEZ BGTZ BLTZ BGEZ J JAL.
//  Arithmetic wraps mod 2^32; no overflow traps; unknown opcodes execute as NOP.
//  Immediates: ADDIU, SLTI, SLTIU, LW, SW and branch offsets sign-extend; ANDI, ORI and XORI zero-extend.
//  LUI = imm<<16. Shifts use shamt[10:6] or rs[4:0] (variable forms).
//  Branch target = PC+4 + (sext(imm)<<2); J/JAL target = {PC+4[31:28], idx, 2'b00}.
//  One branch delay slot: the instruction after any branch/jump always executes before the target.
//  JAL writes PC+8 to $31; JALR writes PC+8 to rd.
//  LW/SW: address = rs + sext(imm), must be word-aligned (misaligned behaviour undefined).
//    SW drives write=1 and writedata=rt.
//  GPR $0 reads 0 always; writes to it are discarded. register_v0 updates the cycle after $2 is written.
//  Halt: when a jump/branch target of 0x00000000 is taken, the delay slot executes, then the CPU enters HALT.
//  HALT: active=0, address=0, read=write=0, all state frozen until reset.
//  Memory access count: 1 per instruction, 2 for LW/SW. CPI = 3 (4 for LW/SW) with waitrequest=0.
// TESTING
//  1. reset high 1 cycle, then low -> next cycle active=1, read=1, address=0xBFC00000, write=0.
//  2. LUI $2,0x1234; ORI $2,$2,0x5678; JR $0; NOP -> active falls, register_v0=0x12345678, address=0.
//  3. Data word 0xDEADBEEF at 0xBFC00100; LW $2 from it; JR $0; NOP -> register_v0=0xDEADBEEF.
//  4. SW $3=0x0000000A to 0xBFC00200, then LW $2 back -> write=1 once with byteenable=4'hF; register_v0=10.
//  5. BEQ $0,$0,+2 with ADDIU $2,$2,1 in the delay slot and ADDIU $2,$2,100 skipped -> register_v0=1.
//  6. waitrequest held high 5 cycles on the first fetch -> address/read held stable; result identical to test 2.

Source files
------------

// File: rtl/mips_cpu_bus_core.sv
// ============================================================================
// Module  : mips_cpu_bus_core
// Brief   : Multi-cycle MIPS-I subset CPU with a single Avalon-style master
//           port shared by instruction fetch and data access.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mips_cpu_bus_core #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_npc;
  logic [31:0] r_gpr [32];
  logic        r_active;
  logic        r_read;
  logic        r_write;
  logic [31:0] r_address;
  logic [31:0] r_writedata;
  logic [31:0] r_result;
  logic [4:0]  r_dest;
  logic        r_taken;
  logic [31:0] r_target;
  logic        r_load;

  // The fetched word is only valid on readdata during EXEC; decode directly from it.
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_sh;
  logic [5:0]  w_fn;
  logic [15:0] w_imm;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [31:0] w_sext;
  logic [31:0] w_zext;
  logic [31:0] w_pc4;
  logic [31:0] w_pc8;
  logic [31:0] w_btgt;
  logic [31:0] w_jtgt;
  logic [31:0] w_ea;

  assign w_op   = readdata[31:26];
  assign w_rs   = readdata[25:21];
  assign w_rt   = readdata[20:16];
  assign w_rd   = readdata[15:11];
  assign w_sh   = readdata[10:6];
  assign w_fn   = readdata[5:0];
  assign w_imm  = readdata[15:0];
  assign w_a    = r_gpr[w_rs];
  assign w_b    = r_gpr[w_rt];
  assign w_sext = {{16{w_imm[15]}}, w_imm};
  assign w_zext = {16'h0000, w_imm};
  assign w_pc4  = r_pc + 32'd4;
  assign w_pc8  = r_pc + 32'd8;
  assign w_btgt = w_pc4 + {w_sext[29:0], 2'b00};
  assign w_jtgt = {w_pc4[31:28], readdata[25:0], 2'b00};
  assign w_ea   = w_a + w_sext;

  logic [31:0] w_res;
  logic [4:0]  w_dest;
  logic        w_taken;
  logic [31:0] w_tgt;
  logic        w_is_lw;
  logic        w_is_sw;

  always_comb begin
    w_res   = 32'd0;
    w_dest  = 5'd0;
    w_taken = 1'b0;
    w_tgt   = w_btgt;
    w_is_lw = 1'b0;
    w_is_sw = 1'b0;
    case (w_op)
      6'h00: begin
        w_dest = w_rd;
        case (w_fn)
          6'h21: w_res = w_a + w_b;
          6'h23: w_res = w_a - w_b;
          6'h24: w_res = w_a & w_b;
          6'h25: w_res = w_a | w_b;
          6'h26: w_res = w_a ^ w_b;
          6'h27: w_res = ~(w_a | w_b);
          6'h2A: w_res = {31'd0, ($signed(w_a) < $signed(w_b))};
          6'h2B: w_res = {31'd0, (w_a < w_b)};
          6'h00: w_res = w_b << w_sh;
          6'h02: w_res = w_b >> w_sh;
          6'h03: w_res = $signed(w_b) >>> w_sh;
          6'h04: w_res = w_b << w_a[4:0];
          6'h06: w_res = w_b >> w_a[4:0];
          6'h07: w_res = $signed(w_b) >>> w_a[4:0];
          6'h08: begin
            w_dest  = 5'd0;
            w_taken = 1'b1;
            w_tgt   = w_a;
          end
          6'h09: begin
            w_res   = w_pc8;
            w_taken = 1'b1;
            w_tgt   = w_a;
          end
          default: w_dest = 5'd0;
        endcase
      end
      6'h01: begin
        if (w_rt == 5'd0) w_taken = w_a[31];
        if (w_rt == 5'd1) w_taken = !w_a[31];
      end
      6'h02: begin
        w_taken = 1'b1;
        w_tgt   = w_jtgt;
      end
      6'h03: begin
        w_taken = 1'b1;
        w_tgt   = w_jtgt;
        w_dest  = 5'd31;
        w_res   = w_pc8;
      end
      6'h04: w_taken = (w_a == w_b);
      6'h05: w_taken = (w_a != w_b);
      6'h06: w_taken = w_a[31] || (w_a == 32'd0);
      6'h07: w_taken = !w_a[31] && (w_a != 32'd0);
      6'h09: begin w_dest = w_rt; w_res = w_a + w_sext; end
      6'h0A: begin w_dest = w_rt; w_res = {31'd0, ($signed(w_a) < $signed(w_sext))}; end
      6'h0B: begin w_dest = w_rt; w_res = {31'd0, (w_a < w_sext)}; end
      6'h0C: begin w_dest = w_rt; w_res = w_a & w_zext; end
      6'h0D: begin w_dest = w_rt; w_res = w_a | w_zext; end
      6'h0E: begin w_dest = w_rt; w_res = w_a ^ w_zext; end
      6'h0F: begin w_dest = w_rt; w_res = {w_imm, 16'h0000}; end
      6'h23: begin w_dest = w_rt; w_is_lw = 1'b1; end
      6'h2B: w_is_sw = 1'b1;
      default: w_dest = 5'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_VECTOR;
      r_npc       <= RESET_VECTOR + 32'd4;
      for (int i = 0; i < 32; i++) r_gpr[i] <= 32'd0;
      r_active    <= 1'b0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_address   <= 32'd0;
      r_writedata <= 32'd0;
      r_result    <= 32'd0;
      r_dest      <= 5'd0;
      r_taken     <= 1'b0;
      r_target    <= 32'd0;
      r_load      <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          // Read is only low here on the first cycle out of reset.
          if (!r_read) begin
            r_read    <= 1'b1;
            r_active  <= 1'b1;
            r_address <= r_pc;
          end else if (!waitrequest) begin
            r_read  <= 1'b0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_result <= w_res;
          r_dest   <= w_dest;
          r_taken  <= w_taken;
          r_target <= w_tgt;
          r_load   <= w_is_lw;
          if (w_is_lw || w_is_sw) begin
            r_address   <= {w_ea[31:2], 2'b00};
            r_read      <= w_is_lw;
            r_write     <= w_is_sw;
            r_writedata <= w_b;
            r_state     <= S_MEM;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (!waitrequest) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_state <= S_WB;
          end
        end
        S_WB: begin
          if (r_dest != 5'd0) r_gpr[r_dest] <= r_load ? readdata : r_result;
          r_pc  <= r_npc;
          r_npc <= r_taken ? r_target : r_npc + 32'd4;
          // Reaching address 0 means the delay slot just retired after a jump to 0.
          if (r_npc == 32'd0) begin
            r_state   <= S_HALT;
            r_active  <= 1'b0;
            r_address <= 32'd0;
          end else begin
            r_state   <= S_FETCH;
            r_read    <= 1'b1;
            r_address <= r_npc;
          end
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign active      = r_active;
  assign register_v0 = r_gpr[2];
  assign address     = r_address;
  assign read        = r_read;
  assign write       = r_write;
  assign writedata   = r_writedata;
  assign byteenable  = 4'b1111;

endmodule

`default_nettype wire

// File: tb/tb_mips_cpu_bus_core.sv
// ============================================================================
// Module  : tb_mips_cpu_bus_core
// Brief   : Self-checking bench for mips_cpu_bus_core with a bus-side memory
//           and an instruction-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mips_cpu_bus_core;
  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = 32'd0;
  logic        active, read, write;
  logic [31:0] register_v0, address, writedata;
  logic [3:0]  byteenable;

  always #5 clk = ~clk;

  mips_cpu_bus_core #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
    .address(address), .write(write), .read(read), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  logic [31:0] mem [logic [31:0]];
  logic [31:0] mm  [logic [31:0]];
  logic [31:0] prog [$];
  int n_vec = 0, n_err = 0;
  int n_reads = 0, n_writes = 0, be_bad = 0, rw_both = 0, stall_left = 0;
  bit rand_wait = 0, pend = 0;
  logic [3:0]  wr_be = 4'h0;
  logic [31:0] pend_a = 32'd0;

  // Slave: decisions made on negedge, read data returned the cycle after acceptance.
  always @(negedge clk) begin
    if (pend) begin
      readdata = mem.exists(pend_a) ? mem[pend_a] : 32'd0;
      pend = 0;
    end
    if (!reset && (read || write)) begin
      if (stall_left > 0) begin waitrequest = 1'b1; stall_left--; end
      else if (rand_wait && $urandom_range(0, 3) == 0) waitrequest = 1'b1;
      else waitrequest = 1'b0;
      if (read && write) rw_both++;
      if (!waitrequest) begin
        if (byteenable != 4'hF) be_bad++;
        if (read) begin pend = 1; pend_a = address; n_reads++; end
        if (write) begin mem[address] = writedata; n_writes++; wr_be = byteenable; end
      end
    end else begin
      waitrequest = 1'b0;
    end
  end

  function automatic logic [31:0] enc_r(int fn, int rs, int rt, int rd, int sh);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
  endfunction
  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction
  function automatic logic [31:0] enc_j(int op, logic [31:0] tgt);
    return {op[5:0], tgt[27:2]};
  endfunction

  task automatic load_prog();
    mem.delete();
    mm.delete();
    foreach (prog[i]) begin
      mem[RV + 32'(4 * i)] = prog[i];
      mm[RV + 32'(4 * i)]  = prog[i];
    end
  endtask

  task automatic start_cpu();
    @(negedge clk);
    reset = 1'b1;
    n_reads = 0; n_writes = 0; be_bad = 0; rw_both = 0; wr_be = 4'h0; pend = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_halt(input int budget, output int cyc, output bit to);
    to = 1; cyc = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      cyc = c + 1;
      if (active === 1'b0) begin to = 0; break; end
    end
  endtask

  // Instruction-level reference: architectural state only, with delay slot.
  task automatic model_run(output logic [31:0] v0, output int nr, output int nw, output bit ok);
    logic [31:0] R [32];
    logic [31:0] pc, npc, ins, a, b, se, ze, tgt, wv, ea;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sh, wd;
    bit taken;
    for (int i = 0; i < 32; i++) R[i] = 32'd0;
    pc = RV; npc = RV + 32'd4; nr = 0; nw = 0; ok = 0;
    for (int step = 0; step < 20000; step++) begin
      ins = mm.exists(pc) ? mm[pc] : 32'd0;
      nr++;
      op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
      sh = ins[10:6]; fn = ins[5:0];
      a = R[rs]; b = R[rt];
      se = {{16{ins[15]}}, ins[15:0]}; ze = {16'd0, ins[15:0]};
      taken = 0; tgt = 32'd0; wd = 5'd0; wv = 32'd0;
      case (op)
        6'h00: case (fn)
          6'h21: begin wd = rd; wv = a + b; end
          6'h23: begin wd = rd; wv = a - b; end
          6'h24: begin wd = rd; wv = a & b; end
          6'h25: begin wd = rd; wv = a | b; end
          6'h26: begin wd = rd; wv = a ^ b; end
          6'h27: begin wd = rd; wv = ~(a | b); end
          6'h2A: begin wd = rd; wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
          6'h2B: begin wd = rd; wv = (a < b) ? 32'd1 : 32'd0; end
          6'h00: begin wd = rd; wv = b << sh; end
          6'h02: begin wd = rd; wv = b >> sh; end
          6'h03: begin wd = rd; wv = $signed(b) >>> sh; end
          6'h04: begin wd = rd; wv = b << a[4:0]; end
          6'h06: begin wd = rd; wv = b >> a[4:0]; end
          6'h07: begin wd = rd; wv = $signed(b) >>> a[4:0]; end
          6'h08: begin taken = 1; tgt = a; end
          6'h09: begin taken = 1; tgt = a; wd = rd; wv = pc + 32'd8; end
          default: ;
        endcase
        6'h01: begin taken = (rt == 5'd0) ? a[31] : (rt == 5'd1) ? !a[31] : 1'b0; tgt = pc + 32'd4 + (se << 2); end
        6'h02: begin taken = 1; tgt = {pc[31:28] + ((pc + 32'd4) >> 28) - pc[31:28], ins[25:0], 2'b00}; end
        6'h03: begin taken = 1; tgt = {4'((pc + 32'd4) >> 28), ins[25:0], 2'b00}; wd = 5'd31; wv = pc + 32'd8; end
        6'h04: begin taken = (a == b); tgt = pc + 32'd4 + (se << 2); end
        6'h05: begin taken = (a != b); tgt = pc + 32'd4 + (se << 2); end
        6'h06: begin taken = ($signed(a) <= 0); tgt = pc + 32'd4 + (se << 2); end
        6'h07: begin taken = ($signed(a) > 0); tgt = pc + 32'd4 + (se << 2); end
        6'h09: begin wd = rt; wv = a + se; end
        6'h0A: begin wd = rt; wv = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
        6'h0B: begin wd = rt; wv = (a < se) ? 32'd1 : 32'd0; end
        6'h0C: begin wd = rt; wv = a & ze; end
        6'h0D: begin wd = rt; wv = a | ze; end
        6'h0E: begin wd = rt; wv = a ^ ze; end
        6'h0F: begin wd = rt; wv = ze << 16; end
        6'h23: begin nr++; ea = a + se; wd = rt; wv = mm.exists(ea) ? mm[ea] : 32'd0; end
        6'h2B: begin nw++; ea = a + se; mm[ea] = b; end
        default: ;
      endcase
      if (op == 6'h02) tgt = {4'((pc + 32'd4) >> 28), ins[25:0], 2'b00};
      if (wd != 5'd0) R[wd] = wv;
      pc = npc;
      npc = taken ? tgt : npc + 32'd4;
      if (pc == 32'd0) begin ok = 1; break; end
    end
    v0 = R[2];
  endtask

  function automatic logic [31:0] rand_alu();
    int d, s, t, sh, k;
    logic [5:0] ops [7] = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    logic [5:0] fns [14] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                             6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    d = $urandom_range(0, 9); s = $urandom_range(0, 10); t = $urandom_range(0, 10);
    sh = $urandom_range(0, 31); k = $urandom_range(0, 20);
    if (k < 14) return enc_r(int'(fns[k]), s, t, d, sh);
    return enc_i(int'(ops[k - 14]), s, d, int'($urandom_range(0, 65535)));
  endfunction

  task automatic gen_prog();
    int kind, j;
    prog.delete();
    for (int r = 1; r <= 9; r++) begin
      prog.push_back(enc_i(6'h0F, 0, r, int'($urandom_range(0, 65535))));
      prog.push_back(enc_i(6'h0D, r, r, int'($urandom_range(0, 65535))));
    end
    prog.push_back(enc_i(6'h0D, 0, 10, 16'h1000));
    for (int k = 0; k < 30; k++) begin
      kind = $urandom_range(0, 9);
      j = prog.size();
      if (kind <= 4 || kind == 9) prog.push_back(rand_alu());
      else if (kind == 5) prog.push_back(enc_i(6'h23, 10, int'($urandom_range(1, 9)), int'($urandom_range(0, 63)) * 4));
      else if (kind == 6) prog.push_back(enc_i(6'h2B, 10, int'($urandom_range(0, 9)), int'($urandom_range(0, 63)) * 4));
      else begin
        if (kind == 8) prog.push_back(enc_j(3, RV + 32'(4 * (j + 3))));
        else case ($urandom_range(0, 5))
          0: prog.push_back(enc_i(4, int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), 2));
          1: prog.push_back(enc_i(5, int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), 2));
          2: prog.push_back(enc_i(6, int'($urandom_range(0, 9)), 0, 2));
          3: prog.push_back(enc_i(7, int'($urandom_range(0, 9)), 0, 2));
          4: prog.push_back(enc_i(1, int'($urandom_range(0, 9)), 0, 2));
          default: prog.push_back(enc_i(1, int'($urandom_range(0, 9)), 1, 2));
        endcase
        prog.push_back(rand_alu());
        prog.push_back(rand_alu());
      end
    end
    for (int r = 1; r <= 31; r++)
      if (r != 2 && (r <= 9 || r == 31)) prog.push_back(enc_r(6'h26, 2, r, 2, 0));
    prog.push_back(32'h0000_0008);
    prog.push_back(32'h0000_0000);
  endtask

  task automatic test_reset();
    int cyc; bit to;
    prog = '{enc_i(6'h0F, 0, 2, 16'h1234), 32'h8, 32'h0};
    load_prog(); rand_wait = 0; stall_left = 0;
    start_cpu(); wait_halt(200, cyc, to);
    n_vec++; if (to || register_v0 !== 32'h12340000) begin n_err++; $display("FAIL reset_pre_v0: got %h want 12340000 (timeout=%0d)", register_v0, to); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b want 0", active); end
    n_vec++; if (read !== 1'b0 || write !== 1'b0) begin n_err++; $display("FAIL reset_rw: got read=%b write=%b want 0/0", read, write); end
    n_vec++; if (register_v0 !== 32'd0) begin n_err++; $display("FAIL reset_v0: got %h want 0", register_v0); end
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (active !== 1'b1 || read !== 1'b1 || write !== 1'b0) begin n_err++; $display("FAIL first_fetch_ctl: got active=%b read=%b write=%b want 1/1/0", active, read, write); end
    n_vec++; if (address !== RV) begin n_err++; $display("FAIL first_fetch_addr: got %h want %h", address, RV); end
    wait_halt(200, cyc, to);
  endtask

  task automatic test_lui_ori();
    int cyc; bit to;
    prog = '{enc_i(6'h0F, 0, 2, 16'h1234), enc_i(6'h0D, 2, 2, 16'h5678), 32'h8, 32'h0};
    load_prog(); start_cpu(); wait_halt(200, cyc, to);
    n_vec++; if (to || register_v0 !== 32'h12345678) begin n_err++; $display("FAIL lui_ori_v0: got %h want 12345678 (timeout=%0d)", register_v0, to); end
    n_vec++; if (address !== 32'd0 || read !== 1'b0 || write !== 1'b0) begin n_err++; $display("FAIL halt_bus: got addr=%h read=%b write=%b want 0/0/0", address, read, write); end
    n_vec++; if (n_reads !== 4) begin n_err++; $display("FAIL lui_ori_reads: got %0d want 4", n_reads); end
    n_vec++; if (cyc !== 13) begin n_err++; $display("FAIL lui_ori_cycles: got %0d want 13", cyc); end
  endtask

  task automatic test_lw();
    int cyc; bit to;
    prog = '{enc_i(6'h0F, 0, 1, 16'hBFC0), enc_i(6'h23, 1, 2, 16'h0100), 32'h8, 32'h0};
    load_prog(); mem[RV + 32'h100] = 32'hDEADBEEF;
    start_cpu(); wait_halt(200, cyc, to);
    n_vec++; if (to || register_v0 !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_v0: got %h want deadbeef (timeout=%0d)", register_v0, to); end
    n_vec++; if (n_reads !== 5 || n_writes !== 0) begin n_err++; $display("FAIL lw_accesses: got reads=%0d writes=%0d want 5/0", n_reads, n_writes); end
  endtask

  task automatic test_sw_lw();
    int cyc; bit to;
    prog = '{enc_i(6'h0F, 0, 1, 16'hBFC0), enc_i(6'h0D, 0, 3, 16'h000A),
             enc_i(6'h2B, 1, 3, 16'h0200), enc_i(6'h23, 1, 2, 16'h0200), 32'h8, 32'h0};
    load_prog(); start_cpu(); wait_halt(200, cyc, to);
    n_vec++; if (to || register_v0 !== 32'd10) begin n_err++; $display("FAIL sw_lw_v0: got %h want 0000000a (timeout=%0d)", register_v0, to); end
    n_vec++; if (n_writes !== 1 || wr_be !== 4'hF) begin n_err++; $display("FAIL sw_write: got writes=%0d be=%h want 1/f", n_writes, wr_be); end
    n_vec++; if (!mem.exists(RV + 32'h200) || mem[RV + 32'h200] !== 32'd10) begin n_err++; $display("FAIL sw_mem: stored word wrong, want 0000000a"); end
    n_vec++; if (rw_both !== 0 || be_bad !== 0) begin n_err++; $display("FAIL sw_bus_rules: got rw_both=%0d be_bad=%0d want 0/0", rw_both, be_bad); end
  endtask

  task automatic test_branch();
    int cyc; bit to;
    prog = '{enc_i(4, 0, 0, 2), enc_i(6'h09, 2, 2, 1), enc_i(6'h09, 2, 2, 100), 32'h8, 32'h0};
    load_prog(); start_cpu(); wait_halt(200, cyc, to);
    n_vec++; if (to || register_v0 !== 32'd1) begin n_err++; $display("FAIL branch_v0: got %h want 00000001 (timeout=%0d)", register_v0, to); end
    n_vec++; if (n_reads !== 4) begin n_err++; $display("FAIL branch_reads: got %0d want 4", n_reads); end
  endtask

  task automatic test_jalr();
    int cyc; bit to;
    prog = '{enc_r(6'h09, 0, 0, 2, 0), 32'h0};
    load_prog(); start_cpu(); wait_halt(200, cyc, to);
    n_vec++; if (to || register_v0 !== RV + 32'd8) begin n_err++; $display("FAIL jalr_link: got %h want %h (timeout=%0d)", register_v0, RV + 32'd8, to); end
  endtask

  task automatic test_waitrequest();
    int cyc; bit to;
    prog = '{enc_i(6'h0F, 0, 2, 16'h1234), enc_i(6'h0D, 2, 2, 16'h5678), 32'h8, 32'h0};
    load_prog(); stall_left = 5;
    start_cpu();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++; if (read !== 1'b1 || address !== RV) begin n_err++; $display("FAIL stall_hold%0d: got read=%b addr=%h want 1/%h", i, read, address, RV); end
    end
    wait_halt(300, cyc, to);
    n_vec++; if (to || register_v0 !== 32'h12345678) begin n_err++; $display("FAIL stall_v0: got %h want 12345678 (timeout=%0d)", register_v0, to); end
    n_vec++; if (n_reads !== 4) begin n_err++; $display("FAIL stall_reads: got %0d want 4", n_reads); end
  endtask

  task automatic test_reset_abort();
    int cyc; bit to;
    prog = '{enc_i(6'h0D, 0, 2, 16'h0055), 32'h8, 32'h0};
    load_prog(); stall_left = 0; start_cpu();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (register_v0 !== 32'd0 || active !== 1'b0 || read !== 1'b0) begin n_err++; $display("FAIL abort_state: got v0=%h active=%b read=%b want 0/0/0", register_v0, active, read); end
    reset = 1'b0;
    wait_halt(200, cyc, to);
    n_vec++; if (to || register_v0 !== 32'h55) begin n_err++; $display("FAIL abort_rerun_v0: got %h want 00000055 (timeout=%0d)", register_v0, to); end
  endtask

  task automatic test_random();
    int cyc, nr, nw, bad; bit to, ok; logic [31:0] v0, da, dv;
    for (int t = 0; t < 24; t++) begin
      gen_prog(); load_prog();
      for (int w = 0; w < 64; w++) begin
        da = 32'h1000 + 32'(4 * w); dv = $urandom;
        mem[da] = dv; mm[da] = dv;
      end
      model_run(v0, nr, nw, ok);
      rand_wait = t[0]; stall_left = 0;
      start_cpu(); wait_halt(5000, cyc, to);
      n_vec++; if (to || !ok || register_v0 !== v0) begin n_err++; $display("FAIL rand%0d_v0: got %h want %h (timeout=%0d)", t, register_v0, v0, to); end
      n_vec++; if (n_reads !== nr || n_writes !== nw) begin n_err++; $display("FAIL rand%0d_accesses: got r=%0d w=%0d want r=%0d w=%0d", t, n_reads, n_writes, nr, nw); end
      bad = 0;
      for (int w = 0; w < 64; w++) begin
        da = 32'h1000 + 32'(4 * w);
        if (mem[da] !== mm[da]) bad++;
      end
      n_vec++; if (bad != 0) begin n_err++; $display("FAIL rand%0d_datamem: got %0d differing words want 0", t, bad); end
      n_vec++; if (be_bad !== 0 || rw_both !== 0 || address !== 32'd0) begin n_err++; $display("FAIL rand%0d_bus: got be_bad=%0d rw_both=%0d addr=%h want 0/0/0", t, be_bad, rw_both, address); end
    end
    rand_wait = 0;
  endtask

  initial begin
    test_reset();
    test_lui_ori();
    test_lw();
    test_sw_lw();
    test_branch();
    test_jalr();
    test_waitrequest();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
